// File: rtl/fpu_pkg.sv
// Shared FPU issue-control definitions: op codes, FSM encoding, ring entry and helpers.
package fpu_pkg;

  localparam logic [1:0] FC_ADD  = 2'b00;
  localparam logic [1:0] FC_MUL  = 2'b01;
  localparam logic [1:0] FC_DIV  = 2'b10;
  localparam logic [1:0] FC_SQRT = 2'b11;

  localparam int unsigned RESV_DEPTH = 32;
  localparam int unsigned NUM_FREG   = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned LAT_W      = 5;
  localparam int unsigned PERF_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    SQRT = 2'b10
  } fsm_state_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] fd;
  } resv_entry_t;

  // Saturating event counter step.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val, input logic en);
    return (en && (val != '1)) ? val + PERF_W'(1) : val;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// ID-stage to FPU issue-control handshake: decoded request in, issue/stall/writeback status out.
interface fpu_issue_ctrl_if;

  logic                         req_valid;
  logic [2:0]                   req_fc;
  logic [fpu_pkg::REG_W-1:0]    req_fs;
  logic [fpu_pkg::REG_W-1:0]    req_ft;
  logic [fpu_pkg::REG_W-1:0]    req_fd;
  logic                         req_use_fs;
  logic                         req_use_ft;
  logic                         req_wf;
  logic                         req_ready;
  logic                         stall_raw;
  logic                         stall_struct;
  logic                         wb_valid;
  logic [fpu_pkg::REG_W-1:0]    wb_fd;
  logic                         unit_busy;
  logic [fpu_pkg::PERF_W-1:0]   perf_issued;
  logic [fpu_pkg::PERF_W-1:0]   perf_raw;
  logic [fpu_pkg::PERF_W-1:0]   perf_struct;

  modport master (
    output req_valid, req_fc, req_fs, req_ft, req_fd, req_use_fs, req_use_ft, req_wf,
    input  req_ready, stall_raw, stall_struct, wb_valid, wb_fd, unit_busy,
    input  perf_issued, perf_raw, perf_struct
  );

  modport slave (
    input  req_valid, req_fc, req_fs, req_ft, req_fd, req_use_fs, req_use_ft, req_wf,
    output req_ready, stall_raw, stall_struct, wb_valid, wb_fd, unit_busy,
    output perf_issued, perf_raw, perf_struct
  );

endinterface

// File: rtl/fpu_resv_ring.sv
// Writeback-slot reservation ring: shifts toward index 0 every cycle, index 0 is the retiring slot.
module fpu_resv_ring
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             wr_en,
  input  logic [LAT_W-1:0] wr_idx,
  input  logic [REG_W-1:0] wr_fd,
  input  logic [LAT_W-1:0] chk_idx,
  output logic             slot_busy_c,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_fd
);

  resv_entry_t ring [RESV_DEPTH];

  // Shift down one slot per cycle; a new reservation lands after the shift.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < RESV_DEPTH; i++) ring[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < RESV_DEPTH - 1; i++) ring[i] <= ring[i+1];
      ring[RESV_DEPTH-1] <= '0;
      if (wr_en) ring[wr_idx] <= resv_entry_t'({1'b1, wr_fd});
    end
  end

  // chk_idx is the entry that will occupy wr_idx after the next shift.
  assign slot_busy_c = ring[chk_idx].v;
  assign wb_valid    = ring[0].v;
  assign wb_fd       = ring[0].fd;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// In-order FP issue controller: register scoreboard, writeback-slot ring and div/sqrt occupancy.
// Optional FPU_ISSUE_PERF_EN adds saturating issue/stall counters.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned DIV_LAT  = 12,
  parameter int unsigned SQRT_LAT = 16
) (
  input  logic           clk,
  input  logic           clrn,
  fpu_issue_ctrl_if.slave bus
);

  localparam logic [LAT_W-1:0] PIPE_L = LAT_W'(PIPE_LAT);
  localparam logic [LAT_W-1:0] DIV_L  = LAT_W'(DIV_LAT);
  localparam logic [LAT_W-1:0] SQRT_L = LAT_W'(SQRT_LAT);

  logic [NUM_FREG-1:0] pend;
  logic [NUM_FREG-1:0] pend_set;
  logic [NUM_FREG-1:0] pend_clr;
  logic [LAT_W-1:0]    lat;
  logic                raw;
  logic                waw;
  logic                strct;
  logic                hazard;
  logic                issue;
  logic                slot_busy_c;
  logic                ring_wb_valid;
  logic [REG_W-1:0]    ring_wb_fd;
  fsm_state_t          state;
  logic [LAT_W-1:0]    cnt;
  logic                busy;
  logic                unused_fc_sub;

  assign unused_fc_sub = bus.req_fc[0];

  // Issue-to-writeback latency of the presented op.
  always_comb begin
    lat = PIPE_L;
    case (bus.req_fc[2:1])
      FC_DIV:  lat = DIV_L;
      FC_SQRT: lat = SQRT_L;
      default: lat = PIPE_L;
    endcase
  end

  // Hazard detection and issue decision.
  always_comb begin
    raw    = (bus.req_use_fs & pend[bus.req_fs]) | (bus.req_use_ft & pend[bus.req_ft]);
    waw    = bus.req_wf & pend[bus.req_fd];
    strct  = (bus.req_fc[2] & busy) | (bus.req_wf & slot_busy_c);
    hazard = raw | waw;
    issue  = bus.req_valid & ~hazard & ~strct;
  end

  assign bus.req_ready    = issue;
  assign bus.stall_raw    = bus.req_valid & hazard;
  assign bus.stall_struct = bus.req_valid & strct & ~hazard;

  fpu_resv_ring u_ring (
    .clk        (clk),
    .clrn       (clrn),
    .wr_en      (issue & bus.req_wf),
    .wr_idx     (lat - LAT_W'(1)),
    .wr_fd      (bus.req_fd),
    .chk_idx    (lat),
    .slot_busy_c(slot_busy_c),
    .wb_valid   (ring_wb_valid),
    .wb_fd      (ring_wb_fd)
  );

  assign bus.wb_valid = ring_wb_valid;
  assign bus.wb_fd    = ring_wb_fd;

  // Scoreboard: set on issue, cleared when the register retires.
  always_comb begin
    pend_set = (issue & bus.req_wf) ? (NUM_FREG'(1) << bus.req_fd) : '0;
    pend_clr = ring_wb_valid ? (NUM_FREG'(1) << ring_wb_fd) : '0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) pend <= '0;
    else       pend <= (pend & ~pend_clr) | pend_set;
  end

  // Div/sqrt occupancy: busy for L-1 cycles after issue, free again in the writeback cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue && bus.req_fc[2]) begin
            state <= bus.req_fc[1] ? SQRT : DIV;
            cnt   <= lat - LAT_W'(2);
            busy  <= 1'b1;
          end
        end
        DIV, SQRT: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unit_busy = busy;

`ifdef FPU_ISSUE_PERF_EN
  logic [PERF_W-1:0] issued_q;
  logic [PERF_W-1:0] raw_q;
  logic [PERF_W-1:0] struct_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      issued_q <= '0;
      raw_q    <= '0;
      struct_q <= '0;
    end else begin
      issued_q <= sat_inc(issued_q, issue);
      raw_q    <= sat_inc(raw_q, bus.stall_raw);
      struct_q <= sat_inc(struct_q, bus.stall_struct);
    end
  end

  assign bus.perf_issued = issued_q;
  assign bus.perf_raw    = raw_q;
  assign bus.perf_struct = struct_q;
`else
  assign bus.perf_issued = '0;
  assign bus.perf_raw    = '0;
  assign bus.perf_struct = '0;
`endif

endmodule
